// File: rtl/bcd_7seg_scan_driver_if.sv
// Bus between a packed-BCD source (master) and the 7-segment scan driver (slave).
// Carries the BCD word, DP request, display enable and the multiplexed display outputs.
interface bcd_7seg_scan_driver_if;
  logic [15:0] bcd_int;
  logic [3:0]  dp_mask;
  logic        disp_en;
  logic [6:0]  seg_out;
  logic        seg_dp;
  logic [3:0]  an_out;
  logic        frame_done;

  modport master (
    output bcd_int, dp_mask, disp_en,
    input  seg_out, seg_dp, an_out, frame_done
  );

  modport slave (
    input  bcd_int, dp_mask, disp_en,
    output seg_out, seg_dp, an_out, frame_done
  );
endinterface

// File: rtl/bcd_7seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver with per-frame snapshot and per-slot blanking.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module bcd_7seg_scan_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                   fpga_clk,
  input  logic                   sys_init_ctrl_n,
  bcd_7seg_scan_driver_if.slave  bus
);

  localparam int             CW         = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  SLOT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [6:0]     SEG_MASK   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic           DP_MASK    = (SEG_ACTIVE_LOW != 0);
  localparam logic [3:0]     AN_MASK    = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic [CW-1:0] r_slot_cnt;
  logic [1:0]    r_dig_idx;
  logic [15:0]   r_snap_bcd;
  logic [3:0]    r_snap_dp;
  logic          r_load_pending;
  logic [6:0]    r_seg_out;
  logic          r_seg_dp;
  logic [3:0]    r_an_out;
  logic          r_frame_done;

  logic          w_slot_last;
  logic          w_load;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg_lit;
  logic          w_lead_blank;
  logic          w_an_on;
  logic [3:0]    w_an_sel;

  // Active-high gfedcba patterns; anything that is not valid BCD shows a dash.
  function automatic logic [6:0] decode7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b1000000;
    endcase
    return p;
  endfunction

  always_comb begin
    w_slot_last = (r_slot_cnt == SLOT_LAST);
    w_load      = r_load_pending || (w_slot_last && (r_dig_idx == 2'd3));
    w_nibble    = r_snap_bcd[{r_dig_idx, 2'b00} +: 4];
    w_an_on     = bus.disp_en && (r_slot_cnt >= SLOT_BLANK);
    w_an_sel    = 4'b0001 << r_dig_idx;
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero only if it and every more significant digit are zero.
  always_comb begin
    w_lead_blank = 1'b0;
    case (r_dig_idx)
      2'd3:    w_lead_blank = (r_snap_bcd[15:12] == 4'd0);
      2'd2:    w_lead_blank = (r_snap_bcd[15:8]  == 8'd0);
      2'd1:    w_lead_blank = (r_snap_bcd[15:4]  == 12'd0);
      default: w_lead_blank = 1'b0;
    endcase
  end
`else
  always_comb begin
    w_lead_blank = 1'b0;
  end
`endif

  always_comb begin
    w_seg_lit = w_lead_blank ? 7'd0 : decode7(w_nibble);
  end

  // Snapshot only changes on the frame's last cycle, so segments settle while the anode is blanked.
  always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) begin
      r_slot_cnt     <= '0;
      r_dig_idx      <= 2'd0;
      r_snap_bcd     <= 16'd0;
      r_snap_dp      <= 4'd0;
      r_load_pending <= 1'b1;
      r_seg_out      <= SEG_MASK;
      r_seg_dp       <= DP_MASK;
      r_an_out       <= AN_MASK;
      r_frame_done   <= 1'b0;
    end else begin
      if (w_slot_last) begin
        r_slot_cnt <= '0;
        r_dig_idx  <= r_dig_idx + 2'd1;
      end else begin
        r_slot_cnt <= r_slot_cnt + CW'(1);
      end
      if (w_load) begin
        r_snap_bcd <= bus.bcd_int;
        r_snap_dp  <= bus.dp_mask;
      end
      r_load_pending <= 1'b0;
      r_frame_done   <= w_load;
      r_seg_out      <= w_seg_lit ^ SEG_MASK;
      r_seg_dp       <= r_snap_dp[r_dig_idx] ^ DP_MASK;
      r_an_out       <= w_an_on ? (w_an_sel ^ AN_MASK) : AN_MASK;
    end
  end

  assign bus.seg_out    = r_seg_out;
  assign bus.seg_dp     = r_seg_dp;
  assign bus.an_out     = r_an_out;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Scoreboard bench for bcd_7seg_scan_driver (SCAN_DIV=8, BLANK_CYCLES=2, active-low outputs).
// Expected per-digit patterns are queued when BCD stimulus is driven and popped per frame.
module tb_bcd_7seg_scan_driver;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
  } expDigit_t;

  logic fpga_clk;
  logic sys_init_ctrl_n;
  int   checkCount;
  int   failCount;
  expDigit_t expQueue[$];

  bcd_7seg_scan_driver_if dispBus ();

  bcd_7seg_scan_driver #(
    .SCAN_DIV       (8),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .fpga_clk        (fpga_clk),
    .sys_init_ctrl_n (sys_init_ctrl_n),
    .bus             (dispBus)
  );

  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  // Active-low segment pattern a digit should show, straight from the decode table.
  function automatic logic [6:0] expSeg(input logic [15:0] bcd, input int d);
    logic [3:0] n;
    logic [6:0] hi;
    n = bcd[d*4 +: 4];
    case (n)
      4'd0:    hi = 7'b0111111;
      4'd1:    hi = 7'b0000110;
      4'd2:    hi = 7'b1011011;
      4'd3:    hi = 7'b1001111;
      4'd4:    hi = 7'b1100110;
      4'd5:    hi = 7'b1101101;
      4'd6:    hi = 7'b1111101;
      4'd7:    hi = 7'b0000111;
      4'd8:    hi = 7'b1111111;
      4'd9:    hi = 7'b1101111;
      default: hi = 7'b1000000;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (bcd >> (4 * d)) == 16'd0) hi = 7'd0;
`endif
    return ~hi;
  endfunction

  task automatic pushFrame(input logic [15:0] bcd, input logic [3:0] dp);
    expDigit_t e;
    for (int d = 0; d < 4; d++) begin
      e.seg = expSeg(bcd, d);
      e.dp  = ~dp[d];
      expQueue.push_back(e);
    end
  endtask

  // Walks one frame starting right after a frame_done sample; k is the output-cycle index in the frame.
  task automatic check_frame(input string tag, input bit first, input int chgAt,
                             input logic [15:0] chgBcd, input logic [3:0] chgDp, input int offAt);
    expDigit_t cur[4];
    logic [3:0] expAn;
    int d;
    int pos;
    if (expQueue.size() < 4) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL %s scoreboard: queue holds %0d entries, required 4", tag, expQueue.size());
      return;
    end
    for (int i = 0; i < 4; i++) cur[i] = expQueue.pop_front();
    for (int k = (first ? 1 : 0); k < 32; k++) begin
      @(negedge fpga_clk);
      d   = k / 8;
      pos = k % 8;
      expAn = 4'hF;
      if (pos >= 2 && !(offAt >= 0 && k > offAt && k <= offAt + 20))
        expAn = ~(4'b0001 << d);
      checkCount++;
      if (dispBus.an_out !== expAn) begin
        failCount++;
        $display("[TB] FAIL %s an_out k=%0d: got %b, required %b", tag, k, dispBus.an_out, expAn);
      end
      checkCount++;
      if (dispBus.seg_out !== cur[d].seg) begin
        failCount++;
        $display("[TB] FAIL %s seg_out k=%0d: got %b, required %b", tag, k, dispBus.seg_out, cur[d].seg);
      end
      checkCount++;
      if (dispBus.seg_dp !== cur[d].dp) begin
        failCount++;
        $display("[TB] FAIL %s seg_dp k=%0d: got %b, required %b", tag, k, dispBus.seg_dp, cur[d].dp);
      end
      checkCount++;
      if (dispBus.frame_done !== (k == 31)) begin
        failCount++;
        $display("[TB] FAIL %s frame_done k=%0d: got %b, required %b", tag, k, dispBus.frame_done, (k == 31));
      end
      if (k == chgAt) begin
        dispBus.bcd_int = chgBcd;
        dispBus.dp_mask = chgDp;
        pushFrame(chgBcd, chgDp);
      end
      if (offAt >= 0 && k == offAt)      dispBus.disp_en = 1'b0;
      if (offAt >= 0 && k == offAt + 20) dispBus.disp_en = 1'b1;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkCount++;
    if (dispBus.an_out !== 4'hF) begin
      failCount++;
      $display("[TB] FAIL %s an_out: got %h, required F", tag, dispBus.an_out);
    end
    checkCount++;
    if (dispBus.seg_out !== 7'h7F) begin
      failCount++;
      $display("[TB] FAIL %s seg_out: got %h, required 7F", tag, dispBus.seg_out);
    end
    checkCount++;
    if (dispBus.seg_dp !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL %s seg_dp: got %b, required 1", tag, dispBus.seg_dp);
    end
    checkCount++;
    if (dispBus.frame_done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL %s frame_done: got %b, required 0", tag, dispBus.frame_done);
    end
  endtask

  task automatic checkFirstLoad(input string tag);
    @(negedge fpga_clk);
    checkCount++;
    if (dispBus.frame_done !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL %s frame_done after release: got %b, required 1", tag, dispBus.frame_done);
    end
    checkCount++;
    if (dispBus.an_out !== 4'hF) begin
      failCount++;
      $display("[TB] FAIL %s an_out after release: got %h, required F", tag, dispBus.an_out);
    end
  endtask

  task automatic test_reset();
    sys_init_ctrl_n = 1'b0;
    dispBus.bcd_int = 16'h1234;
    dispBus.dp_mask = 4'b0000;
    dispBus.disp_en = 1'b1;
    repeat (3) @(negedge fpga_clk);
    checkResetOutputs("reset_hold");
    pushFrame(16'h1234, 4'b0000);
    sys_init_ctrl_n = 1'b1;
    checkFirstLoad("reset_release");
  endtask

  task automatic test_full_frame();
    check_frame("frame_1234", 1'b1, -1, 16'h0, 4'h0, -1);
  endtask

  task automatic test_snapshot_hold();
    pushFrame(16'h1234, 4'b0000);
    check_frame("hold_1234", 1'b0, 12, 16'h5678, 4'b0000, -1);
    check_frame("new_5678", 1'b0, 12, 16'h00A7, 4'b0100, -1);
  endtask

  task automatic test_invalid_dp();
    check_frame("dash_dp", 1'b0, 12, 16'h0005, 4'b0000, -1);
  endtask

  task automatic test_leading_zero();
    check_frame("lead_zero", 1'b0, -1, 16'h0, 4'h0, -1);
  endtask

  task automatic test_disp_en();
    pushFrame(16'h0005, 4'b0000);
    check_frame("disp_en_off", 1'b0, -1, 16'h0, 4'h0, 5);
  endtask

  task automatic test_reset_mid();
    repeat (12) @(negedge fpga_clk);
    sys_init_ctrl_n = 1'b0;
    #1;
    checkResetOutputs("reset_mid_now");
    dispBus.bcd_int = 16'h9081;
    dispBus.dp_mask = 4'b1001;
    repeat (2) @(negedge fpga_clk);
    checkResetOutputs("reset_mid_held");
    pushFrame(16'h9081, 4'b1001);
    sys_init_ctrl_n = 1'b1;
    checkFirstLoad("reset_mid_release");
    check_frame("restart_9081", 1'b1, -1, 16'h0, 4'h0, -1);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    test_reset();
    test_full_frame();
    test_snapshot_hold();
    test_invalid_dp();
    test_leading_zero();
    test_disp_en();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
